count_display_driver: RTL

- Downstream consumer of the 4-bit up/down counter value.
- Registers the counter's `count`, converts it to two decimal digits (00..15) and time-multiplexes them onto a 2-digit common-anode seven-segment display.
- Leading zero is blanked.
- Sits between the counter core and the board display pins.

---
 rtl/count_display_driver.sv | 126 ++++++++++++
 1 files changed

// File: rtl/count_display_driver.sv
// Registers the 4-bit counter value and scans it as two decimal digits onto a
// 2-digit seven-segment display. Optional WRAP_BLINK_EN lights dp after a count wrap.
module count_display_driver #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned WRAP_HOLD      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_MASK = {7{SEG_ACTIVE_LOW}};
  localparam logic [1:0] AN_MASK  = {2{AN_ACTIVE_LOW}};

  typedef enum logic {ONES, TENS} digit_t;

  digit_t        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [3:0]    count_q;
  logic          tens;
  logic [3:0]    ones;
  logic [6:0]    seg_d;
  logic [1:0]    an_d;
  logic          dp_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  assign tens = (count_q >= 4'd10);
  assign ones = tens ? (count_q - 4'd10) : count_q;

  always_comb begin
    rcnt_d  = rcnt_q + 1'b1;
    state_d = state_q;
    if (rcnt_q == RLAST) begin
      rcnt_d  = '0;
      state_d = (state_q == ONES) ? TENS : ONES;
    end
  end

  // Tens digit keeps its enable even when blanked, so the scan duty stays even.
  always_comb begin
    seg_d = SEG_MASK;
    an_d  = AN_MASK;
    if (state_q == ONES) begin
      seg_d = seg_code(ones) ^ SEG_MASK;
      an_d  = 2'b01 ^ AN_MASK;
    end else begin
      seg_d = (tens ? seg_code(4'd1) : 7'h00) ^ SEG_MASK;
      an_d  = 2'b10 ^ AN_MASK;
    end
  end

`ifdef WRAP_BLINK_EN
  localparam int unsigned HW = (WRAP_HOLD > 0) ? $clog2(WRAP_HOLD + 1) : 1;

  logic [3:0]    prev_q;
  logic [HW-1:0] hold_q;
  logic          wrap;

  assign wrap = ((prev_q == 4'd15) && (count_q == 4'd0)) ||
                ((prev_q == 4'd0)  && (count_q == 4'd15));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      hold_q <= '0;
    end else begin
      prev_q <= count_q;
      if (wrap)
        hold_q <= HW'(WRAP_HOLD);
      else if (hold_q != '0)
        hold_q <= hold_q - 1'b1;
    end
  end

  always_comb begin
    dp_d = SEG_ACTIVE_LOW;
    if ((hold_q != '0) && (state_q == ONES))
      dp_d = ~SEG_ACTIVE_LOW;
  end
`else
  always_comb begin
    dp_d = SEG_ACTIVE_LOW;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      rcnt_q  <= '0;
      state_q <= ONES;
      seg     <= SEG_MASK;
      an      <= AN_MASK;
      dp      <= SEG_ACTIVE_LOW;
    end else begin
      count_q <= count;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      seg     <= seg_d;
      an      <= an_d;
      dp      <= dp_d;
    end
  end

endmodule
